// File: rtl/instr_fetch.sv
// Fetch stage: reads a BYTES-wide instruction one byte per ROM access and hands it to decode.
// Define FETCH_SKIP_NOP_EN to consume all-zero (NOP) instructions inside the stage.
module instr_fetch #(
  parameter int BYTES    = 6,
  parameter int ROM_WAIT = 1,
  parameter int LOG      = 0
) (
  input  logic               CP,
  input  logic               _MR,
  input  logic [7:0]         PCHI,
  input  logic [7:0]         PCLO,
  input  logic               _flush,
  input  logic [7:0]         rom_data,
  input  logic               ir_ready,
  output logic [18:0]        rom_addr,
  output logic [8*BYTES-1:0] IR,
  output logic               ir_valid,
  output logic               pc_next
);

  localparam int IRW = 8 * BYTES;

  // LOG only selects simulation tracing; the synthesizable core carries no trace output
  if (BYTES < 1 || BYTES > 8 || ROM_WAIT < 0 || ROM_WAIT > 15 || LOG < 0 || LOG > 1) begin : g_bad_param
    $error("instr_fetch: BYTES must be 1..8, ROM_WAIT 0..15, LOG 0..1");
  end

  typedef enum logic [1:0] {IDLE, READ, HOLD, SKIP} state_e;

  state_e          state_q, state_d;
  logic [15:0]     pc_base_q, pc_base_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [IRW-1:0]  ir_q, ir_d;

  always_ff @(posedge CP or negedge _MR) begin
    if (!_MR) begin
      state_q    <= IDLE;
      pc_base_q  <= '0;
      byte_idx_q <= '0;
      wcnt_q     <= '0;
      ir_q       <= '0;
    end else begin
      state_q    <= state_d;
      pc_base_q  <= pc_base_d;
      byte_idx_q <= byte_idx_d;
      wcnt_q     <= wcnt_d;
      ir_q       <= ir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_base_d  = pc_base_q;
    byte_idx_d = byte_idx_q;
    wcnt_d     = wcnt_q;
    ir_d       = ir_q;
    pc_next    = 1'b0;

    // IDLE re-latches the PC every cycle, including while flush is held low
    if (state_q == IDLE) begin
      pc_base_d  = {PCHI, PCLO};
      byte_idx_d = '0;
      wcnt_d     = '0;
    end

    if (!_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = READ;
        READ: begin
          if (wcnt_q != 4'(ROM_WAIT)) begin
            wcnt_d = wcnt_q + 4'd1;
          end else begin
            wcnt_d = '0;
            ir_d[{byte_idx_q, 3'b000} +: 8] = rom_data;
            if (byte_idx_q == 3'(BYTES - 1)) begin
`ifdef FETCH_SKIP_NOP_EN
              state_d = (ir_d == '0) ? SKIP : HOLD;
`else
              state_d = HOLD;
`endif
            end else begin
              byte_idx_d = byte_idx_q + 3'd1;
            end
          end
        end
        HOLD: begin
          if (ir_ready) begin
            pc_next = 1'b1;
            state_d = IDLE;
          end
        end
        SKIP: begin
          pc_next = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rom_addr = {pc_base_q, byte_idx_q};
  assign IR       = ir_q;
  assign ir_valid = (state_q == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a cycle-index model.
module tb_instr_fetch;

  localparam int B = 6;
  localparam int W = 1;
  localparam int L = 1 + B * (W + 1);

  logic           CP = 1'b0;
  logic           _MR, _flush, ir_ready;
  logic [7:0]     PCHI, PCLO, rom_data;
  logic [18:0]    rom_addr;
  logic [8*B-1:0] IR;
  logic           ir_valid, pc_next;

  int             n_chk = 0;
  int             n_fail = 0;
  bit             mon_en = 1'b0;
  int             rom_mode = 0;
  logic [15:0]    pc;

  // model: m_t = cycles since IDLE entry (0 = IDLE, L = holding, -1 = NOP being retired)
  int             m_t = 0;
  logic [15:0]    m_pc = '0;
  logic [18:0]    m_addr = '0;
  logic [8*B-1:0] m_ir = '0;

  instr_fetch #(.BYTES(B), .ROM_WAIT(W), .LOG(0)) dut (
    .CP(CP), ._MR(_MR), .PCHI(PCHI), .PCLO(PCLO), ._flush(_flush),
    .rom_data(rom_data), .ir_ready(ir_ready), .rom_addr(rom_addr),
    .IR(IR), .ir_valid(ir_valid), .pc_next(pc_next)
  );

  always #5 CP = ~CP;

  function automatic logic [7:0] rom_fn(logic [18:0] a, int mode);
    logic [31:0] h;
    h = {13'b0, a} * 32'h9E3779B1;
    case (mode)
      0:       return 8'h10 + {5'b0, a[2:0]};
      1:       return h[23:16];
      default: return 8'h00;
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr, rom_mode);

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pc = '0; m_addr = '0; m_ir = '0;
  endtask

  task automatic model_step();
    int k;
    if (!_MR) return;
    if (!_flush) begin
      if (m_t == 0) begin
        m_pc = {PCHI, PCLO};
        m_addr = {m_pc, 3'b000};
      end
      m_t = 0;
    end else if (m_t == -1) begin
      m_t = 0;
    end else if (m_t == 0) begin
      m_pc = {PCHI, PCLO};
      m_addr = {m_pc, 3'b000};
      m_t = 1;
    end else if (m_t < L) begin
      if ((m_t - 1) % (W + 1) == W) begin
        k = (m_t - 1) / (W + 1);
        m_ir[8*k +: 8] = rom_fn(m_addr, rom_mode);
        if (k < B - 1) m_addr = {m_pc, 3'(k + 1)};
      end
      m_t++;
`ifdef FETCH_SKIP_NOP_EN
      if (m_t == L && m_ir == '0) m_t = -1;
`endif
    end else if (ir_ready) begin
      m_t = 0;
    end
  endtask

  // compare process: inputs are stable from posedge+1 until the next posedge
  always @(negedge CP) begin
    if (mon_en) begin
      if (!_MR) model_reset();
      check("mdl_rom_addr", rom_addr, m_addr);
      check("mdl_ir", IR, m_ir);
      check("mdl_ir_valid", ir_valid, m_t == L);
      check("mdl_pc_next", pc_next, _MR && _flush && ((m_t == L && ir_ready) || m_t == -1));
      model_step();
    end
  end

  task automatic drive_pc();
    PCHI = pc[15:8];
    PCLO = pc[7:0];
  endtask

  // one clock; acts as PC control by advancing pc after a pc_next strobe
  task automatic tick();
    logic adv;
    @(negedge CP);
    adv = pc_next;
    @(posedge CP);
    #1;
    if (adv) pc = pc + 16'd1;
    drive_pc();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ir_valid && n < 40) begin
      tick();
      n++;
    end
    check("wait_valid", ir_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int nps;
    int tp[3];
    bit seen_valid;

    _MR = 1'b0; _flush = 1'b1; ir_ready = 1'b0; pc = 16'h1234; rom_mode = 0;
    drive_pc();
    mon_en = 1'b1;
    tick(); tick();
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ir", IR, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_pc_next", pc_next, 0);

    // first fetch from 0x1234
    _MR = 1'b1;
    e = 0;
    while (!ir_valid && e < 40) begin
      tick();
      e++;
      if (e <= 12) check("addr_step", rom_addr, 19'h091A0 + 19'((e - 1) / 2));
    end
    check("first_latency", e, 13);
    check("first_ir", IR, 48'h151413121110);

    // hold without acceptance, then accept
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ir", IR, 48'h151413121110);
      check("hold_valid", ir_valid, 1);
      check("hold_no_pcn", pc_next, 0);
    end
    ir_ready = 1'b1;
    #1 check("accept_pcn", pc_next, 1);
    tick();
    ir_ready = 1'b0;
    check("accept_drop", ir_valid, 0);
    check("pcn_one_cycle", pc_next, 0);
    tick();
    check("idle_latch", rom_addr, 19'h091A8);

    // flush during byte 3 with a jump to 0x8000
    e = 0;
    while (rom_addr[2:0] != 3'd3 && e < 40) begin
      tick();
      e++;
    end
    check("reach_byte3", rom_addr[2:0], 3);
    pc = 16'h8000; drive_pc(); _flush = 1'b0;
    #1 check("flush_pcn", pc_next, 0);
    tick();
    _flush = 1'b1;
    check("flush_valid", ir_valid, 0);
    tick();
    check("flush_restart", rom_addr, 19'h40000);

    // flush wins over ir_ready in HOLD
    wait_valid(e);
    _flush = 1'b0; ir_ready = 1'b1;
    #1 check("fr_pcn", pc_next, 0);
    tick();
    _flush = 1'b1; ir_ready = 1'b0;
    check("fr_valid", ir_valid, 0);

    // async reset mid-READ
    tick(); tick(); tick();
    _MR = 1'b0;
    #1;
    check("mr_ir", IR, 0);
    check("mr_valid", ir_valid, 0);
    check("mr_rom_addr", rom_addr, 0);
    tick();
    _MR = 1'b1;
    wait_valid(e);
    check("mr_latency", e, 13);
    check("mr_ir_after", IR, 48'h151413121110);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;

    // randomized traffic
    rom_mode = 1;
    repeat (3000) begin
      tick();
      ir_ready = 1'($urandom_range(0, 1));
      _flush   = ($urandom_range(0, 39) != 0);
      _MR      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 15) == 0) begin
        pc = 16'($urandom);
        drive_pc();
      end
    end

    // all-zero ROM from PC 0 with decode always ready
    rom_mode = 2; _MR = 1'b0; _flush = 1'b1; ir_ready = 1'b1; pc = 16'h0000;
    drive_pc();
    tick();
    _MR = 1'b1;
    nps = 0; seen_valid = 1'b0; tp = '{0, 0, 0};
    for (int c = 0; c < 80 && nps < 3; c++) begin
      tick();
      if (ir_valid) seen_valid = 1'b1;
      if (pc_next) begin
        tp[nps] = c;
        nps++;
      end
    end
    check("nop_pulses", nps, 3);
    check("nop_gap1", tp[1] - tp[0], 14);
    check("nop_gap2", tp[2] - tp[1], 14);
`ifdef FETCH_SKIP_NOP_EN
    check("nop_no_valid", seen_valid, 0);
`else
    check("nop_presented", seen_valid, 1);
`endif

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
